// File: rtl/pid_pkg.sv
// pid_pkg: shared types, widths and saturation helpers for the PID sample
// scheduler and its multiply-accumulate unit.
//   pid_state_e  : sequencer states (IDLE..SUM), one cycle each after IDLE
//   sat_iw       : clamp an IW+1 bit sum into the signed IW-bit integrator
//   clamp_out    : clamp the scaled accumulator into the unsigned DW-bit output
//   out_sat      : flag that clamp_out had to clamp
package pid_pkg;

  localparam int DW    = 8;   // setpoint / feedback / output width
  localparam int GW    = 8;   // gain width, unsigned Q4.4
  localparam int IW    = 12;  // integrator width, signed
  localparam int DIVW  = 16;  // sample divider width
  localparam int ACC_W = 22;  // accumulator width, signed
  localparam int FRAC  = 4;   // fractional bits of the gains
  localparam int OPW   = 12;  // multiplier operand width, signed
  localparam int PRODW = OPW + GW + 1;  // signed x zero-extended unsigned
  localparam int YW    = ACC_W - FRAC;  // width of acc >>> FRAC

  localparam logic signed [IW-1:0] INTEG_MAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] INTEG_MIN = {1'b1, {(IW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_MUL_P   = 3'd2,
    S_MUL_I   = 3'd3,
    S_MUL_D   = 3'd4,
    S_SUM     = 3'd5
  } pid_state_e;

  // The sum of two IW-bit values overflowed iff its two top bits differ;
  // the top bit then tells the direction.
  function automatic logic signed [IW-1:0] sat_iw(input logic signed [IW:0] v);
    if (v[IW] != v[IW-1]) begin
      return v[IW] ? INTEG_MIN : INTEG_MAX;
    end
    return v[IW-1:0];
  endfunction

  function automatic logic [DW-1:0] clamp_out(input logic signed [YW-1:0] y);
    if (y[YW-1]) begin
      return '0;
    end
    if (|y[YW-2:DW]) begin
      return '1;
    end
    return y[DW-1:0];
  endfunction

  function automatic logic out_sat(input logic signed [YW-1:0] y);
    return y[YW-1] | (|y[YW-2:DW]);
  endfunction

endpackage

// File: rtl/pid_mac.sv
// pid_mac: shared signed x unsigned multiplier feeding a signed accumulator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the accumulator (has priority over acc_en)
//   acc_en     : add op * gain into the accumulator
//   op         : signed OPW-bit operand
//   gain       : unsigned GW-bit gain (Q4.4), zero-extended before multiply
//   acc_shr    : accumulator arithmetically shifted right by FRAC
module pid_mac
  import pid_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   acc_en,
  input  logic signed [OPW-1:0]  op,
  input  logic        [GW-1:0]   gain,
  output logic signed [YW-1:0]   acc_shr
);

  logic signed [PRODW-1:0] op_x;
  logic signed [PRODW-1:0] gain_x;
  logic signed [PRODW-1:0] prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  // Extend both operands to the product width first; the exact product of
  // a 12-bit signed and a 9-bit non-negative value always fits in PRODW.
  assign op_x   = PRODW'(op);
  assign gain_x = $signed(PRODW'({1'b0, gain}));
  assign prod   = op_x * gain_x;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Dropping the FRAC fraction bits is the >>> FRAC of the output scaling.
  assign acc_shr = acc_q[ACC_W-1:FRAC];

endmodule

// File: rtl/pid_sample_scheduler.sv
// pid_sample_scheduler: sample-rate divider plus six-state sequencer that
// captures the inputs and time-shares one multiplier over the P, I, D terms.
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : run the tick counter; low while idle clears integ/e_prev
//   setpoint        : target value, unsigned
//   feedback        : measured value, unsigned
//   kp, ki, kd      : gains, unsigned Q4.4
//   sample_div      : one tick every sample_div+1 cycles
//   control_signal  : clamped output, registered
//   ctrl_valid      : one-cycle pulse when control_signal updates
//   busy            : sequencer not in IDLE
//   sat             : last output was clamped
//   overrun         : sticky, a tick arrived while busy; cleared by enable=0
//   dbg_state       : current sequencer state
// Handshake: ctrl_valid is a pure strobe with no ready; the consumer must
// take control_signal in the cycle ctrl_valid is high.
module pid_sample_scheduler
  import pid_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [DW-1:0]   setpoint,
  input  logic [DW-1:0]   feedback,
  input  logic [GW-1:0]   kp,
  input  logic [GW-1:0]   ki,
  input  logic [GW-1:0]   kd,
  input  logic [DIVW-1:0] sample_div,
  output logic [DW-1:0]   control_signal,
  output logic            ctrl_valid,
  output logic            busy,
  output logic            sat,
  output logic            overrun,
  output pid_state_e      dbg_state
);

  pid_state_e state_q, state_d;

  logic [DIVW-1:0]       cnt_q, cnt_d;
  logic                  tick;
  logic signed [DW:0]    e_new;
  logic signed [DW+1:0]  d_new;
  logic signed [IW:0]    integ_sum;
  logic signed [DW:0]    e_q;
  logic signed [DW+1:0]  d_q;
  logic signed [IW-1:0]  integ_q;
  logic signed [DW:0]    e_prev_q;
  logic [GW-1:0]         kp_q, ki_q, kd_q;
  logic [DW-1:0]         ctrl_q;
  logic                  valid_q, sat_q, overrun_q;
  logic signed [OPW-1:0] mac_op;
  logic [GW-1:0]         mac_gain;
  logic signed [YW-1:0]  y;

  // ---------------- tick counter ----------------
  assign tick = enable && (cnt_q == sample_div);

  always_comb begin
    cnt_d = cnt_q + DIVW'(1);
    if (!enable || cnt_q >= sample_div) begin
      cnt_d = '0;
    end
  end

  // ---------------- sequencer ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (tick) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_MUL_P;
      S_MUL_P:   state_d = S_MUL_I;
      S_MUL_I:   state_d = S_MUL_D;
      S_MUL_D:   state_d = S_SUM;
      S_SUM:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------- error terms, computed from live inputs in CAPTURE ----------------
  assign e_new     = $signed({1'b0, setpoint}) - $signed({1'b0, feedback});
  assign d_new     = {e_new[DW], e_new} - {e_prev_q[DW], e_prev_q};
  assign integ_sum = {integ_q[IW-1], integ_q} + {{(IW-DW){e_new[DW]}}, e_new};

  // ---------------- multiplier operand select ----------------
  always_comb begin
    mac_op   = '0;
    mac_gain = '0;
    case (state_q)
      S_MUL_P: begin
        mac_op   = {{(OPW-DW-1){e_q[DW]}}, e_q};
        mac_gain = kp_q;
      end
      S_MUL_I: begin
        mac_op   = integ_q;
        mac_gain = ki_q;
      end
      S_MUL_D: begin
        mac_op   = {{(OPW-DW-2){d_q[DW+1]}}, d_q};
        mac_gain = kd_q;
      end
      default: ;
    endcase
  end

  pid_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == S_CAPTURE),
    .acc_en  (state_q == S_MUL_P || state_q == S_MUL_I || state_q == S_MUL_D),
    .op      (mac_op),
    .gain    (mac_gain),
    .acc_shr (y)
  );

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      e_q       <= '0;
      d_q       <= '0;
      integ_q   <= '0;
      e_prev_q  <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_q == S_SUM);

      if (state_q == S_CAPTURE) begin
        kp_q     <= kp;
        ki_q     <= ki;
        kd_q     <= kd;
        e_q      <= e_new;
        d_q      <= d_new;
        integ_q  <= sat_iw(integ_sum);
        e_prev_q <= e_new;
      end else if (state_q == S_IDLE && !enable) begin
        // A sequence already running when enable drops finishes first; the
        // history is only wiped once we are back in IDLE.
        integ_q  <= '0;
        e_prev_q <= '0;
      end

      if (state_q == S_SUM) begin
        ctrl_q <= clamp_out(y);
        sat_q  <= out_sat(y);
      end

      if (!enable) begin
        overrun_q <= 1'b0;
      end else if (tick && state_q != S_IDLE) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign control_signal = ctrl_q;
  assign ctrl_valid     = valid_q;
  assign busy           = (state_q != S_IDLE);
  assign sat            = sat_q;
  assign overrun        = overrun_q;
  assign dbg_state      = state_q;

endmodule
